ps2_key_decoder: RTL

Parametrised PS/2 keyboard receiver that replaces the raw 33-bit shift-register capture with a framed, checked, event-oriented interface. It synchronises PS2_CLK/PS2_DAT and validates each 11-bit frame (start, 8 data, odd parity, stop). It folds E0/F0 prefixes into single key events, tracks Shift state, and buffers events in a FIFO with a valid/ready handshake. It sits between the board PS/2 pins and the key-type classifier / FSM logic.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_frame_rx.sv | 100 ++++++++++
 rtl/ps2_key_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       shift;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin synchroniser, falling-edge detect and 11-bit frame checker with
// mid-frame timeout. Emits one registered byte_valid or frame_err pulse per frame.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, dat_s, fall;

  frame_state_e state_q;
  logic [2:0]   bit_idx_q;
  logic [7:0]   shift_q;
  logic         parity_ok_q;
  logic [TMO_W-1:0] tmo_q;
  logic         byte_valid_q, frame_err_q;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  // Idle PS/2 lines are high, so the chain resets high to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
      clk_prev_q <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      parity_ok_q  <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q != ST_IDLE && !fall && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
        tmo_q       <= '0;
      end else begin
        tmo_q <= (fall || state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
        if (fall) begin
          unique case (state_q)
            ST_IDLE: if (!dat_s) begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
            end
            ST_DATA: begin
              shift_q   <= {dat_s, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) state_q <= ST_PARITY;
            end
            ST_PARITY: begin
              // Odd parity: data plus parity bit carry an odd number of ones.
              parity_ok_q <= ^{shift_q, dat_s};
              state_q     <= ST_STOP;
            end
            ST_STOP: begin
              if (dat_s && parity_ok_q) byte_valid_q <= 1'b1;
              else                      frame_err_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into key events, tracks Shift,
// and buffers events in a show-ahead FIFO with a valid/ready handshake.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                            CLOCK_50,
  input  logic                            Resetn,
  input  logic                            PS2_CLK,
  input  logic                            PS2_DAT,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [7:0]                      evt_code,
  output logic                            evt_ext,
  output logic                            evt_break,
  output logic                            evt_shift,
  output logic                            frame_err,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       byte_valid;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (CLOCK_50),
    .rst_n     (Resetn),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  logic ext_q, ext_d, brk_q, brk_d;
  logic lshift_q, lshift_d, rshift_q, rshift_d;
  logic push_req;
  ps2_evt_t new_evt;

  always_comb begin
    // NOTE: every signal gets a default before the branches so no path
    // leaves it unassigned, which would otherwise infer a latch.
    ext_d    = ext_q;
    brk_d    = brk_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    push_req = 1'b0;
    new_evt  = '0;
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (!ext_q && rx_byte == PS2_LSHIFT) lshift_d = ~brk_q;
        if (!ext_q && rx_byte == PS2_RSHIFT) rshift_d = ~brk_q;
        push_req = 1'b1;
        new_evt  = '{code: rx_byte, ext: ext_q, brk: brk_q, shift: lshift_d | rshift_d};
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end
  end

  ps2_evt_t         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, pop, push_ok;

  always_comb begin
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = (count_q != '0) && evt_ready;
    push_ok    = push_req && (!full || pop);
    overflow_d = overflow_q | (push_req & full & ~pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset; the count gates the head to zero
  // while empty, so stale contents are never visible.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem_q[wr_ptr_q] <= new_evt;
  end

  ps2_evt_t head;
  always_comb head = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  assign evt_valid  = (count_q != '0);
  assign evt_code   = head.code;
  assign evt_ext    = head.ext;
  assign evt_break  = head.brk;
  assign evt_shift  = head.shift;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule
